// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit ALU command path: unit selects, compare codes, issuer FSM.
package alu_pkg;

    localparam int unsigned OpcodeWidth = 4;
    localparam int unsigned NumUnits    = 4;

    typedef enum logic [1:0] {
        UnitArith = 2'b00,
        UnitLogic = 2'b01,
        UnitCmp   = 2'b10,
        UnitShift = 2'b11
    } unit_e;

    // Used both as the CMP function code and as the result code the unit returns.
    typedef enum logic [1:0] {
        CmpNone = 2'b00,
        CmpEq   = 2'b01,
        CmpGt   = 2'b10,
        CmpLt   = 2'b11
    } cmp_code_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

    function automatic logic [NumUnits-1:0] unit_onehot(input unit_e unit);
        logic [NumUnits-1:0] oh;
        oh       = '0;
        oh[unit] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cmp_code_checker.sv
// Validates a compare unit's result code against the requested function; purely combinational.
module cmp_code_checker
    import alu_pkg::*;
#(
    parameter int unsigned ResWidth = 32
) (
    input  logic [1:0]          func_i,
    input  logic [ResWidth-1:0] unit_res_i,
    input  logic                is_cmp_i,
    output logic                violation_o,
    output logic                hit_o
);

    logic [1:0] code;
    logic       upper_set;
    logic       code_bad;

    assign code      = unit_res_i[1:0];
    assign upper_set = (unit_res_i[ResWidth-1:2] != '0);
    // A compare may only report "no match" or the exact relation it was asked about.
    assign code_bad  = (code != CmpNone) && (code != func_i);

    assign hit_o       = is_cmp_i && (code != CmpNone);
    assign violation_o = is_cmp_i && (upper_set || code_bad);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation per command handshake, waits for the unit's flag pulse and returns
// the result (or a timeout / compare-code error) on the response port.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned ResWidth  = 32,
    parameter int unsigned Timeout   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [OpcodeWidth-1:0] cmd_opcode_i,
    input  logic [DataWidth-1:0]   cmd_a_i,
    input  logic [DataWidth-1:0]   cmd_b_i,
    output logic [DataWidth-1:0]   op_a_o,
    output logic [DataWidth-1:0]   op_b_o,
    output logic [1:0]             alu_func_o,
    output logic                   arith_en_o,
    output logic                   logic_en_o,
    output logic                   cmp_en_o,
    output logic                   shift_en_o,
    input  logic [ResWidth-1:0]    unit_res_i,
    input  logic                   unit_flag_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ResWidth-1:0]    rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   rsp_cmp_hit_o
);

    localparam int unsigned CntWidth = $clog2(Timeout + 1);

    state_e                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [OpcodeWidth-1:0] opcode_q;
    logic [NumUnits-1:0]    unit_en_q;
    logic [DataWidth-1:0]   op_a_q;
    logic [DataWidth-1:0]   op_b_q;
    logic [1:0]             alu_func_q;
    logic [ResWidth-1:0]    rsp_data_q;
    logic                   rsp_err_q;
    logic                   rsp_cmp_hit_q;

    logic                   is_cmp;
    logic                   cmp_violation;
    logic                   cmp_hit;

    assign is_cmp = (opcode_q[3:2] == UnitCmp);

    cmp_code_checker #(
        .ResWidth(ResWidth)
    ) u_cmp_code_checker (
        .func_i     (opcode_q[1:0]),
        .unit_res_i (unit_res_i),
        .is_cmp_i   (is_cmp),
        .violation_o(cmp_violation),
        .hit_o      (cmp_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            opcode_q      <= '0;
            unit_en_q     <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            alu_func_q    <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_cmp_hit_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        op_a_q     <= cmd_a_i;
                        op_b_q     <= cmd_b_i;
                        alu_func_q <= cmd_opcode_i[1:0];
                        opcode_q   <= cmd_opcode_i;
                        unit_en_q  <= unit_onehot(unit_e'(cmd_opcode_i[3:2]));
                        state_q    <= StIssue;
                    end
                end
                // Any flag seen here belongs to an earlier operation, so it is not sampled.
                StIssue: begin
                    unit_en_q <= '0;
                    cnt_q     <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (unit_flag_i) begin
                        rsp_data_q    <= unit_res_i;
                        rsp_err_q     <= cmp_violation;
                        rsp_cmp_hit_q <= cmp_hit;
                        state_q       <= StResp;
                    end else if (cnt_q == CntWidth'(Timeout - 1)) begin
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_cmp_hit_q <= 1'b0;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign alu_func_o    = alu_func_q;
    assign arith_en_o    = unit_en_q[UnitArith];
    assign logic_en_o    = unit_en_q[UnitLogic];
    assign cmp_en_o      = unit_en_q[UnitCmp];
    assign shift_en_o    = unit_en_q[UnitShift];
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_cmp_hit_o = rsp_cmp_hit_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a 1-cycle-latency unit model and flag injection.
module tb_alu_op_issuer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  alu_func;
    logic        arith_en;
    logic        logic_en;
    logic        cmp_en;
    logic        shift_en;
    logic [31:0] unit_res;
    logic        unit_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_cmp_hit;

    // Unit model controls and state
    logic        model_on;
    logic        use_ops;
    logic [31:0] model_res;
    logic        model_flag_q;
    logic [31:0] model_res_q;
    logic        inj_flag;
    logic [31:0] inj_res;
    logic        any_en;

    int n_cmp;
    int n_mis;
    int cyc;

    alu_op_issuer #(
        .DataWidth(16),
        .ResWidth (32),
        .Timeout  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .op_a_o       (op_a),
        .op_b_o       (op_b),
        .alu_func_o   (alu_func),
        .arith_en_o   (arith_en),
        .logic_en_o   (logic_en),
        .cmp_en_o     (cmp_en),
        .shift_en_o   (shift_en),
        .unit_res_i   (unit_res),
        .unit_flag_i  (unit_flag),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .rsp_cmp_hit_o(rsp_cmp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign any_en = arith_en | logic_en | cmp_en | shift_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_flag_q <= 1'b0;
            model_res_q  <= '0;
        end else begin
            model_flag_q <= model_on && any_en;
            model_res_q  <= (model_on && any_en) ? (use_ops ? {op_a, op_b} : model_res) : '0;
        end
    end

    assign unit_flag = model_flag_q | inj_flag;
    assign unit_res  = model_res_q | inj_res;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check issue-side outputs, latency and response; optionally hold off RSP_READY.
    task automatic run_op(input string tag, input logic [3:0] opc, input logic [15:0] a,
                          input logic [15:0] b, input logic on, input logic [31:0] res,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                          input logic exp_hit, input int hold);
        int lat;
        logic [3:0] exp_en;
        exp_en     = 4'b0001 << opc[3:2];
        model_on   = on;
        model_res  = res;
        cmd_opcode = opc;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq({tag, "_en_onehot"}, {shift_en, cmp_en, logic_en, arith_en}, exp_en);
        check_eq({tag, "_operands"}, {op_a, op_b, alu_func}, {a, b, opc[1:0]});
        check_eq({tag, "_busy"}, cmd_ready, 1'b0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check_eq({tag, "_en_clear"}, any_en, 1'b0);
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_rsp"}, {rsp_data, rsp_err, rsp_cmp_hit}, {exp_data, exp_err, exp_hit});
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                inj_flag = 1'b1;
                inj_res  = 32'hdead_beef;
            end
            @(posedge clk); #1;
            inj_flag = 1'b0;
            inj_res  = '0;
            check_eq({tag, "_hold"}, {rsp_valid, cmd_ready, rsp_data, rsp_err, rsp_cmp_hit},
                     {1'b1, 1'b0, exp_data, exp_err, exp_hit});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_done"}, {cmd_ready, rsp_valid}, 2'b10);
    endtask

    logic [3:0]  b2b_opc [3];
    logic [15:0] b2b_a   [3];
    logic [15:0] b2b_b   [3];

    initial begin
        int last_acc;
        int n;
        n_cmp      = 0;
        n_mis      = 0;
        cyc        = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b0;
        model_on   = 1'b0;
        use_ops    = 1'b0;
        model_res  = '0;
        inj_flag   = 1'b0;
        inj_res    = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ready", {cmd_ready, rsp_valid}, 2'b10);
        check_eq("reset_issue", {op_a, op_b, alu_func, shift_en, cmp_en, logic_en, arith_en}, '0);
        check_eq("reset_rsp", {rsp_data, rsp_err, rsp_cmp_hit}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("cmp_eq", 4'b1001, 16'h1234, 16'h1234, 1'b1, 32'h1, 2, 32'h1, 1'b0, 1'b1, 0);
        run_op("cmp_gt_bad", 4'b1010, 16'h0005, 16'h0003, 1'b1, 32'h3, 2, 32'h3, 1'b1, 1'b1, 0);
        run_op("cmp_none", 4'b1000, 16'h0001, 16'h0002, 1'b1, 32'h0, 2, 32'h0, 1'b0, 1'b0, 0);
        run_op("cmp_upper", 4'b1011, 16'h0001, 16'h0009, 1'b1, 32'h7, 2, 32'h7, 1'b1, 1'b1, 0);
        run_op("logic_nochk", 4'b0101, 16'h00f0, 16'h0f0f, 1'b1, 32'h3, 2, 32'h3, 1'b0, 1'b0, 0);
        run_op("timeout", 4'b0000, 16'h1111, 16'h2222, 1'b0, 32'h0, 5, 32'h0, 1'b1, 1'b0, 0);
        run_op("backpress", 4'b1101, 16'h00aa, 16'h0003, 1'b1, 32'h0000_0550, 2, 32'h0000_0550,
               1'b0, 1'b0, 5);

        // Reset while waiting on an ARITH op whose unit never answers.
        model_on   = 1'b0;
        cmd_opcode = 4'b0010;
        cmd_a      = 16'hbeef;
        cmd_b      = 16'h0001;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_eq("rst_mid_async", {cmd_ready, rsp_valid, any_en}, 3'b100);
        @(posedge clk); #1;
        rst      = 1'b0;
        inj_flag = 1'b1;
        inj_res  = 32'h5;
        @(posedge clk); #1;
        inj_flag = 1'b0;
        inj_res  = '0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_mid_quiet", {cmd_ready, rsp_valid, any_en, rsp_data, rsp_err},
                     {3'b100, 32'h0, 1'b0});
            @(posedge clk); #1;
        end

        // Back-to-back with CMD_VALID and RSP_READY held high.
        b2b_opc[0] = 4'b0001; b2b_a[0] = 16'h1357; b2b_b[0] = 16'h2468;
        b2b_opc[1] = 4'b0110; b2b_a[1] = 16'hface; b2b_b[1] = 16'h0042;
        b2b_opc[2] = 4'b1111; b2b_a[2] = 16'h8001; b2b_b[2] = 16'h0004;
        model_on  = 1'b1;
        use_ops   = 1'b1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        last_acc  = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_opcode = b2b_opc[i];
            cmd_a      = b2b_a[i];
            cmd_b      = b2b_b[i];
            n = 0;
            @(negedge clk);
            while (!cmd_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
            if (i == 2) cmd_valid = 1'b0;
            if (i > 0) check_eq("b2b_gap", cyc - last_acc, 4);
            last_acc = cyc;
            check_eq("b2b_en", {shift_en, cmp_en, logic_en, arith_en}, 4'b0001 << b2b_opc[i][3:2]);
            n = 0;
            while (!rsp_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq("b2b_rsp", {rsp_valid, rsp_data, rsp_err},
                     {1'b1, b2b_a[i], b2b_b[i], 1'b0});
        end
        @(posedge clk); #1;
        check_eq("b2b_end", {cmd_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
